// File: rtl/slicel_cfg_loader.sv
// slicel_cfg_loader
//   Configuration front-end for slicel. Collects the slice bitstream as a
//   stream of WORD_W-bit words (valid/ready), assembles it in a shadow
//   register and commits the complete image to the slicel config outputs
//   in a single edge, so slicel never sees a partially written image.
//
// Optional build macro:
//   CFG_CHK_EN - after the data words, one extra checksum word is accepted.
//                It must equal the XOR of all data words (pad bits included);
//                on a mismatch the load is rejected, the old image is kept and
//                cfg_err is raised.
//
// Ports:
//   cclk                  config clock (only clock)
//   rst_n                 synchronous active-low reset
//   start                 one-cycle pulse, begins or restarts a load
//   in_data / in_valid    bitstream word and its valid
//   in_ready              word accepted this cycle when in_valid is also high
//   luts_config_in        image bits [CFG_SIZE*NUM_LUTS-1:0]
//   inter_lut_mux_config  next MUX_LVLS image bits
//   config_use_cc         next image bit
//   regs_config_in        top 2*NUM_LUTS image bits
//   cen                   to slicel: 1 = config mode, 0 = run
//   cfg_done              active image valid
//   cfg_err               last load rejected (always 0 without CFG_CHK_EN)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset, waiting for start
// LOAD   | accepting bitstream words into the shadow register
// COMMIT | one cycle; shadow copied to the config outputs
// DONE   | image live, slicel running (cen=0)
// ERR    | checksum mismatch, old image kept (CFG_CHK_EN builds only)

module slicel_cfg_loader #(
  parameter  int S_XX_BASE = 4,
  parameter  int NUM_LUTS  = 4,
  parameter  int WORD_W    = 8,
  localparam int CFG_SIZE  = 2 * (2 ** S_XX_BASE) + 1,
  localparam int MUX_LVLS  = $clog2(NUM_LUTS),
  localparam int CFG_BITS  = CFG_SIZE * NUM_LUTS + MUX_LVLS + 1 + 2 * NUM_LUTS,
  localparam int NUM_WORDS = (CFG_BITS + WORD_W - 1) / WORD_W
) (
  input  logic                         cclk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [WORD_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [CFG_SIZE*NUM_LUTS-1:0] luts_config_in,
  output logic [MUX_LVLS-1:0]          inter_lut_mux_config,
  output logic                         config_use_cc,
  output logic [2*NUM_LUTS-1:0]        regs_config_in,
  output logic                         cen,
  output logic                         cfg_done,
  output logic                         cfg_err
);

  localparam int LUT_BITS = CFG_SIZE * NUM_LUTS;
  localparam int MUX_LSB  = LUT_BITS;
  localparam int CC_BIT   = LUT_BITS + MUX_LVLS;
  localparam int REGS_LSB = CC_BIT + 1;
  // Room for one more count than the data words, so the checksum slot fits.
  localparam int CNT_W    = $clog2(NUM_WORDS + 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_COMMIT = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    word_cnt;
  logic [CFG_BITS-1:0] shadow;
  logic                accept;
  logic                last_data;

`ifdef CFG_CHK_EN
  logic [WORD_W-1:0]   xor_acc;
  logic                chk_word;
`endif

  assign accept    = in_valid & in_ready;
  assign last_data = (word_cnt == CNT_W'(NUM_WORDS - 1));
`ifdef CFG_CHK_EN
  assign chk_word  = (word_cnt == CNT_W'(NUM_WORDS));
`endif

  // Next state and combinational outputs. start overrides everything:
  // from any state it (re)opens a fresh load.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cfg_err   = 1'b0;

    if (state == S_LOAD) begin
      in_ready = !start;
    end
`ifdef CFG_CHK_EN
    if (state == S_ERR) begin
      cfg_err = 1'b1;
    end
`endif

    if (start) begin
      state_nxt = S_LOAD;
    end else begin
      case (state)
        S_IDLE:   state_nxt = S_IDLE;
        S_LOAD: begin
          if (accept) begin
`ifdef CFG_CHK_EN
            if (chk_word) begin
              state_nxt = (in_data == xor_acc) ? S_COMMIT : S_ERR;
            end
`else
            if (last_data) begin
              state_nxt = S_COMMIT;
            end
`endif
          end
        end
        S_COMMIT: state_nxt = S_DONE;
        S_DONE:   state_nxt = S_DONE;
        S_ERR:    state_nxt = S_ERR;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      word_cnt             <= '0;
      shadow               <= '0;
      luts_config_in       <= '0;
      inter_lut_mux_config <= '0;
      config_use_cc        <= 1'b0;
      regs_config_in       <= '0;
      cen                  <= 1'b1;
      cfg_done             <= 1'b0;
    end else begin
      state <= state_nxt;

      // cen/cfg_done are registered from the current state, so they follow
      // DONE one edge later; a start seen in DONE raises cen on that edge.
      cen      <= !((state == S_DONE) && !start);
      cfg_done <= (state == S_DONE) && !start;

      if (start) begin
        word_cnt <= '0;
      end else if (accept) begin
        word_cnt <= word_cnt + CNT_W'(1);
        // Word k lands at bits [k*WORD_W +: WORD_W]; pad bits past the
        // image are simply not stored.
        for (int k = 0; k < NUM_WORDS; k++) begin
          for (int b = 0; b < WORD_W; b++) begin
            if (k * WORD_W + b < CFG_BITS) begin
              if (word_cnt == CNT_W'(k)) begin
                shadow[k*WORD_W+b] <= in_data[b];
              end
            end
          end
        end
      end

      if ((state == S_COMMIT) && !start) begin
        luts_config_in       <= shadow[LUT_BITS-1:0];
        inter_lut_mux_config <= shadow[MUX_LSB +: MUX_LVLS];
        config_use_cc        <= shadow[CC_BIT];
        regs_config_in       <= shadow[REGS_LSB +: 2*NUM_LUTS];
      end
    end
  end

`ifdef CFG_CHK_EN
  // Running XOR over the data words only; the checksum word is compared
  // against the value accumulated before it.
  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      xor_acc <= '0;
    end else if (start) begin
      xor_acc <= '0;
    end else if (accept && !chk_word) begin
      xor_acc <= xor_acc ^ in_data;
    end
  end
`endif

endmodule

// File: tb/tb_slicel_cfg_loader.sv
module tb_slicel_cfg_loader;

  localparam int NW = 18;
  localparam int CB = 143;
`ifdef CFG_CHK_EN
  localparam int TOTAL = NW + 1;
`else
  localparam int TOTAL = NW;
`endif

  logic         cclk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [131:0] luts_config_in;
  logic [1:0]   inter_lut_mux_config;
  logic         config_use_cc;
  logic [7:0]   regs_config_in;
  logic         cen;
  logic         cfg_done;
  logic         cfg_err;

  int tests = 0;
  int fails = 0;

  logic [7:0]    img_w [TOTAL];
  logic [CB-1:0] live;

  always #5 cclk = ~cclk;

  slicel_cfg_loader dut (
    .cclk                 (cclk),
    .rst_n                (rst_n),
    .start                (start),
    .in_data              (in_data),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .luts_config_in       (luts_config_in),
    .inter_lut_mux_config (inter_lut_mux_config),
    .config_use_cc        (config_use_cc),
    .regs_config_in       (regs_config_in),
    .cen                  (cen),
    .cfg_done             (cfg_done),
    .cfg_err              (cfg_err)
  );

  task automatic chk(input string tag, input logic [CB-1:0] obs, input logic [CB-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_img(input string tag, input logic [CB-1:0] v);
    chk({tag, "_luts"}, CB'(luts_config_in), CB'(v[131:0]));
    chk({tag, "_mux"},  CB'(inter_lut_mux_config), CB'(v[133:132]));
    chk({tag, "_cc"},   CB'(config_use_cc), CB'(v[134]));
    chk({tag, "_regs"}, CB'(regs_config_in), CB'(v[142:135]));
  endtask

  // Image implied by the data words: word k covers bits [8k+7:8k].
  function automatic logic [CB-1:0] img_of();
    logic [CB-1:0] v;
    v = '0;
    for (int k = 0; k < NW; k++)
      for (int b = 0; b < 8; b++)
        if (k * 8 + b < CB) v[k*8+b] = img_w[k][b];
    return v;
  endfunction

  task automatic set_chk(input bit corrupt);
`ifdef CFG_CHK_EN
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < NW; k++) x = x ^ img_w[k];
    img_w[NW] = corrupt ? (x ^ 8'h10) : x;
`else
    if (corrupt) img_w[0] = img_w[0];
`endif
  endtask

  task automatic rand_words();
    for (int k = 0; k < NW; k++) img_w[k] = 8'($urandom);
    set_chk(1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge cclk); #1;
    start = 1'b0;
  endtask

  // Present words first..last; mode 0 = valid held, 1 = toggling, 2 = random.
  // Returns at 1 time unit past the edge that accepted the last word.
  task automatic feed(input int first, input int last, input int mode, output int acc);
    int  idx;
    int  cyc;
    bit  got;
    idx = first;
    cyc = 0;
    acc = 0;
    while (idx <= last && cyc < 400) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? img_w[idx] : 8'($urandom);
      #1;
      got = in_valid && in_ready;
      if (got) acc++;
      @(posedge cclk); #1;
      if (got) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 400) chk("feed_timeout", CB'(idx), CB'(last + 1));
  endtask

  // Commit timing: old image held at edge N, new image at N+1, run mode at N+2.
  task automatic commit_seq(input string tag);
    logic [CB-1:0] nv;
    nv = img_of();
    chk_img({tag, "_holdN"}, live);
    chk({tag, "_doneN"}, CB'(cfg_done), CB'(0));
    @(posedge cclk); #1;
    chk_img({tag, "_newN1"}, nv);
    chk({tag, "_doneN1"}, CB'(cfg_done), CB'(0));
    chk({tag, "_cenN1"}, CB'(cen), CB'(1));
    @(posedge cclk); #1;
    chk({tag, "_doneN2"}, CB'(cfg_done), CB'(1));
    chk({tag, "_cenN2"}, CB'(cen), CB'(0));
    chk({tag, "_rdyN2"}, CB'(in_ready), CB'(0));
    chk({tag, "_errN2"}, CB'(cfg_err), CB'(0));
    live = nv;
  endtask

  initial begin
    int acc;
    int cyc;
    logic [CB-1:0] v;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    live = '0;
    repeat (3) @(posedge cclk);
    #1;
    chk_img("rst", '0);
    chk("rst_cen", CB'(cen), CB'(1));
    chk("rst_done", CB'(cfg_done), CB'(0));
    chk("rst_err", CB'(cfg_err), CB'(0));
    chk("rst_rdy", CB'(in_ready), CB'(0));
    rst_n = 1'b1;
    in_valid = 1'b1;
    @(posedge cclk); #1;
    chk("idle_rdy", CB'(in_ready), CB'(0));
    in_valid = 1'b0;

    // Directed image: word0=0F, word1=FA, rest zero.
    for (int k = 0; k < NW; k++) img_w[k] = 8'h00;
    img_w[0] = 8'h0F; img_w[1] = 8'hFA;
    set_chk(1'b0);
    pulse_start();
    feed(0, TOTAL - 1, 0, acc);
    chk("t1_accepts", CB'(acc), CB'(TOTAL));
    commit_seq("t1");
    chk("t1_lo16", CB'(luts_config_in[15:0]), CB'(16'hFA0F));

    // Forced fields, toggling valid, fixed window to count every accept.
    v = '0;
    for (int i = 0; i < CB; i++) v[i] = 1'($urandom);
    v[142:135] = 8'hA5;
    v[133:132] = 2'b10;
    for (int k = 0; k < NW; k++)
      for (int b = 0; b < 8; b++)
        img_w[k][b] = (k * 8 + b < CB) ? v[k*8+b] : 1'($urandom);
    set_chk(1'b0);
    pulse_start();
    acc = 0;
    for (cyc = 0; cyc < 3 * TOTAL + 10; cyc++) begin
      in_valid = (cyc % 2 == 0);
      in_data  = (acc < TOTAL) ? img_w[acc] : 8'($urandom);
      #1;
      if (in_valid && in_ready) acc++;
      @(posedge cclk); #1;
    end
    in_valid = 1'b0;
    chk("t2_accepts", CB'(acc), CB'(TOTAL));
    chk("t2_regs", CB'(regs_config_in), CB'(8'hA5));
    chk("t2_mux", CB'(inter_lut_mux_config), CB'(2'b10));
    chk_img("t2_img", v);
    chk("t2_done", CB'(cfg_done), CB'(1));
    live = v;

    // Partial reload: old image must stay visible until the commit edge.
    rand_words();
    pulse_start();
    feed(0, 8, 0, acc);
    chk("t3_cen", CB'(cen), CB'(1));
    chk("t3_done", CB'(cfg_done), CB'(0));
    chk_img("t3_hold", live);
    feed(9, TOTAL - 1, 2, acc);
    commit_seq("t3");

    // Restart at word 5 with a word on the bus.
    rand_words();
    pulse_start();
    feed(0, 4, 0, acc);
    start = 1'b1; in_valid = 1'b1; in_data = img_w[5];
    #1;
    chk("t4_rdy_on_start", CB'(in_ready), CB'(0));
    @(posedge cclk); #1;
    start = 1'b0; in_valid = 1'b0;
    chk_img("t4_hold", live);
    rand_words();
    feed(0, TOTAL - 1, 0, acc);
    chk("t4_accepts", CB'(acc), CB'(TOTAL));
    commit_seq("t4");

    // Reset in the middle of a load.
    rand_words();
    pulse_start();
    feed(0, 9, 0, acc);
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'($urandom);
    @(posedge cclk); #1;
    rst_n = 1'b1;
    live = '0;
    chk_img("t5_rst", live);
    chk("t5_cen", CB'(cen), CB'(1));
    chk("t5_done", CB'(cfg_done), CB'(0));
    chk("t5_err", CB'(cfg_err), CB'(0));
    for (int i = 0; i < 3; i++) begin
      in_data = 8'($urandom);
      #1;
      chk("t5_rdy", CB'(in_ready), CB'(0));
      @(posedge cclk); #1;
    end
    in_valid = 1'b0;
    chk_img("t5_still_rst", live);
    rand_words();
    pulse_start();
    feed(0, TOTAL - 1, 1, acc);
    commit_seq("t5");

    // Random images with random valid patterns.
    for (int r = 0; r < 3; r++) begin
      rand_words();
      pulse_start();
      feed(0, TOTAL - 1, 2, acc);
      chk("rnd_accepts", CB'(acc), CB'(TOTAL));
      commit_seq("rnd");
    end

`ifdef CFG_CHK_EN
    // Bad checksum: rejected, old image kept, start clears the error.
    rand_words();
    set_chk(1'b1);
    pulse_start();
    feed(0, TOTAL - 1, 0, acc);
    chk("chk_err", CB'(cfg_err), CB'(1));
    @(posedge cclk); #1;
    @(posedge cclk); #1;
    chk("chk_err_hold", CB'(cfg_err), CB'(1));
    chk("chk_err_cen", CB'(cen), CB'(1));
    chk("chk_err_done", CB'(cfg_done), CB'(0));
    chk("chk_err_rdy", CB'(in_ready), CB'(0));
    chk_img("chk_err_img", live);
    pulse_start();
    chk("chk_err_clr", CB'(cfg_err), CB'(0));
    set_chk(1'b0);
    feed(0, TOTAL - 1, 0, acc);
    commit_seq("chk_ok");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
